// File: rtl/mode_seq_pkg.sv
// Purpose: shared types and helpers for the mode step arbiter (state enum, mode wrap, round-robin pick).
// Latency: combinational helpers only.
// Backpressure: none.
package mode_seq_pkg;

  // Widest requester vector the round-robin helper accepts.
  localparam int MAX_REQ = 32;
  localparam int MAX_REQ_W = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Modulo increment; the top mode wraps back to zero.
  function automatic int next_mode(input int m, input int num_modes);
    return (m == num_modes - 1) ? 0 : m + 1;
  endfunction

  // First set bit of pend at or above ptr, wrapping within n_req.
  // Returns 0 when nothing is set; callers only use it with a non-empty vector.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] pend, input int ptr, input int n_req);
    int   idx;
    int   win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n_req) begin
        idx = ptr + k;
        if (idx >= n_req) idx = idx - n_req;
        if (!found && pend[idx[MAX_REQ_W-1:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mode_step_arbiter_if.sv
// Purpose: control/status bundle between request front-end and the mode step arbiter.
// Latency: wires only.
// Backpressure: none; busy/pending are advisory status.
interface mode_step_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int NUM_MODES = 3
);
  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int ID_W   = $clog2(N_REQ);

  logic              en;
  logic [N_REQ-1:0]  req_in;
  logic              load_valid;
  logic [MODE_W-1:0] load_mode;
  logic              drop_clr;

  logic [MODE_W-1:0] mode;
  logic              step_pulse;
  logic [ID_W-1:0]   grant_id;
  logic              busy;
  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  drop_sticky;
  logic              load_err;

  // Control side: drives requests and configuration, observes status.
  modport master (
    output en, req_in, load_valid, load_mode, drop_clr,
    input  mode, step_pulse, grant_id, busy, pending, drop_sticky, load_err
  );

  // Arbiter side.
  modport slave (
    input  en, req_in, load_valid, load_mode, drop_clr,
    output mode, step_pulse, grant_id, busy, pending, drop_sticky, load_err
  );

endinterface

// File: rtl/rise_pulse.sv
// Purpose: per-bit rising-edge detector on synchronous request levels.
// Latency: combinational rise vector against last cycle's level.
// Backpressure: none.
module rise_pulse #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;

  // Previous level; resets to ones so lines already high at release never count as a rise.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '1;
    else     prev_q <= lvl;
  end

  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/mode_step_arbiter.sv
// Purpose: round-robin arbiter stepping one shared modulo mode register, with hold-off lockout and direct load.
// Latency: request rise at t -> pending at t+1 -> step_pulse/new mode at t+2 when idle and enabled.
// Backpressure: en=0 or lockout holds requests in pending; a repeat rise while pending is dropped and flagged.
module mode_step_arbiter
  import mode_seq_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int NUM_MODES = 3,
  parameter int HOLDOFF   = 2
) (
  input logic               clk,
  input logic               rst,
  mode_step_arbiter_if.slave bus
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int CNT_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [MODE_W-1:0] mode_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [N_REQ-1:0]  pending_q;
  logic [N_REQ-1:0]  drop_q;
  logic              step_q;
  logic              load_err_q;

  logic [N_REQ-1:0]  rise;
  logic              grant_fire;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   rr_next;
  logic [MODE_W-1:0] mode_inc;
  logic [N_REQ-1:0]  grant_vec;
  logic [N_REQ-1:0]  pending_nxt;
  logic [N_REQ-1:0]  drop_set;
  logic [N_REQ-1:0]  drop_nxt;
  logic              load_ok;

  rise_pulse #(.W(N_REQ)) u_rise (
    .clk  (clk),
    .rst  (rst),
    .lvl  (bus.req_in),
    .rise (rise)
  );

  // A load in the same cycle takes priority over a grant; pending simply waits a cycle.
  assign grant_fire = (state_q == ST_IDLE) && bus.en && (|pending_q) && !bus.load_valid;
  assign winner     = ID_W'(rr_pick(MAX_REQ'(pending_q), int'(rr_ptr_q), N_REQ));
  assign rr_next    = (int'(winner) == N_REQ - 1) ? '0 : ID_W'(int'(winner) + 1);
  assign mode_inc   = MODE_W'(next_mode(int'(mode_q), NUM_MODES));
  assign grant_vec  = grant_fire ? (N_REQ'(1) << winner) : '0;

  // A fresh rise on the granted requester re-arms it in the same cycle.
  assign pending_nxt = (pending_q & ~grant_vec) | rise;
  assign drop_set    = rise & pending_q & ~grant_vec;
  assign drop_nxt    = (bus.drop_clr ? '0 : drop_q) | drop_set;

  assign load_ok = (int'(bus.load_mode) < NUM_MODES);

  // Arbitration FSM together with mode, request bookkeeping and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      mode_q     <= '0;
      grant_id_q <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      step_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_nxt;
      drop_q     <= drop_nxt;
      step_q     <= grant_fire;
      load_err_q <= bus.load_valid && !load_ok;

      if (bus.load_valid) begin
        if (load_ok) mode_q <= bus.load_mode;
      end else if (grant_fire) begin
        mode_q <= mode_inc;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_fire) begin
            state_q    <= ST_LOCK;
            cnt_q      <= CNT_W'(HOLDOFF);
            grant_id_q <= winner;
            rr_ptr_q   <= rr_next;
          end
        end
        ST_LOCK: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mode        = mode_q;
  assign bus.step_pulse  = step_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q == ST_LOCK);
  assign bus.pending     = pending_q;
  assign bus.drop_sticky = drop_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_mode_step_arbiter.sv
// Purpose: self-checking bench for mode_step_arbiter; scoreboard of expected (grant_id, mode) per step.
// Latency: steps are matched in order as step_pulse appears.
// Backpressure: exercises en=0 holds, lockout spacing, loads and reset mid-lock.
module tb_mode_step_arbiter;
  import mode_seq_pkg::*;

  localparam int N_REQ     = 4;
  localparam int NUM_MODES = 3;
  localparam int HOLDOFF   = 2;

  typedef struct {
    int id;
    int mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mode_step_arbiter_if #(.N_REQ(N_REQ), .NUM_MODES(NUM_MODES)) bus ();

  mode_step_arbiter #(
    .N_REQ     (N_REQ),
    .NUM_MODES (NUM_MODES),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_steps   = 0;
  int   exp_steps = 0;
  int   cyc       = 0;
  int   last_step = -1;
  exp_t sb[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_step(input int id, input int mode);
    exp_t e;
    e.id   = id;
    e.mode = mode;
    sb.push_back(e);
    exp_steps++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Step monitor: pops the scoreboard and checks spacing between consecutive steps.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_step = -1;
    end else if (bus.step_pulse) begin
      n_steps++;
      if (sb.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        e = sb.pop_front();
        check("step_grant_id", int'(bus.grant_id), e.id);
        check("step_mode", int'(bus.mode), e.mode);
      end
      if (last_step >= 0) check("step_gap_ok", int'(cyc - last_step >= HOLDOFF + 2), 1);
      last_step = cyc;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    next_cyc();
  endtask

  initial begin
    bus.en         = 1'b1;
    bus.req_in     = '0;
    bus.load_valid = 1'b0;
    bus.load_mode  = '0;
    bus.drop_clr   = 1'b0;

    // Reset values
    next_cyc();
    next_cyc();
    sample();
    check("rst_mode", int'(bus.mode), 0);
    check("rst_grant_id", int'(bus.grant_id), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_drop", int'(bus.drop_sticky), 0);
    check("rst_step", int'(bus.step_pulse), 0);
    check("rst_load_err", int'(bus.load_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    next_cyc();
    rst = 1'b0;
    next_cyc();

    // 1: single request, latency and lockout length
    bus.req_in[1] = 1'b1;
    expect_step(1, 1);
    next_cyc(); sample();
    check("t1_pending", int'(bus.pending), 2);
    check("t1_busy_pre", int'(bus.busy), 0);
    check("t1_step_early", int'(bus.step_pulse), 0);
    next_cyc(); sample();
    check("t1_step", int'(bus.step_pulse), 1);
    check("t1_busy0", int'(bus.busy), 1);
    check("t1_pending_clr", int'(bus.pending), 0);
    next_cyc(); sample();
    check("t1_busy1", int'(bus.busy), 1);
    check("t1_step_once", int'(bus.step_pulse), 0);
    next_cyc(); sample();
    check("t1_busy2", int'(bus.busy), 1);
    next_cyc(); sample();
    check("t1_idle", int'(bus.busy), 0);
    bus.req_in = '0;

    // 2: three simultaneous requests from rr_ptr=0, mode wraps
    reset_dut();
    bus.req_in = 4'b1101;
    expect_step(0, 1);
    expect_step(2, 2);
    expect_step(3, 0);
    for (int k = 1; k <= 11; k++) begin
      next_cyc(); sample();
      check($sformatf("t2_step_c%0d", k), int'(bus.step_pulse), int'(k == 2 || k == 6 || k == 10));
    end
    next_cyc();
    bus.req_in = '0;
    next_cyc();
    // rr_ptr back at 0: requester 1 must win over 3
    bus.req_in = 4'b1010;
    expect_step(1, 1);
    expect_step(3, 2);
    repeat (10) next_cyc();
    bus.req_in = '0;
    sample();
    check("t2_steps", n_steps, exp_steps);

    // 3: en=0 holds pending without stepping
    next_cyc();
    bus.en = 1'b0;
    bus.req_in[2] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      next_cyc(); sample();
      check($sformatf("t3_hold_c%0d", k), int'(bus.pending), 4);
    end
    check("t3_no_step", n_steps, exp_steps);
    next_cyc();
    bus.en = 1'b1;
    expect_step(2, 0);
    repeat (6) next_cyc();
    sample();
    check("t3_pending_clr", int'(bus.pending), 0);
    check("t3_steps", n_steps, exp_steps);
    bus.req_in = '0;

    // 4: repeat rise while pending is dropped and flagged
    next_cyc();
    bus.en = 1'b0;
    bus.req_in[1] = 1'b1;
    next_cyc();
    bus.req_in[1] = 1'b0;
    next_cyc();
    bus.req_in[1] = 1'b1;
    next_cyc(); sample();
    check("t4_drop_set", int'(bus.drop_sticky), 2);
    check("t4_pending", int'(bus.pending), 2);
    next_cyc(); sample();
    check("t4_drop_sticky", int'(bus.drop_sticky), 2);
    bus.en = 1'b1;
    expect_step(1, 1);
    repeat (6) next_cyc();
    sample();
    check("t4_one_step", n_steps, exp_steps);
    check("t4_drop_kept", int'(bus.drop_sticky), 2);
    next_cyc();
    bus.drop_clr = 1'b1;
    next_cyc();
    bus.drop_clr = 1'b0;
    sample();
    check("t4_drop_clr", int'(bus.drop_sticky), 0);
    bus.req_in = '0;

    // 5: direct load, out-of-range load, load colliding with a grant
    next_cyc();
    bus.load_valid = 1'b1;
    bus.load_mode  = 2'd2;
    next_cyc();
    bus.load_valid = 1'b0;
    sample();
    check("t5_load_mode", int'(bus.mode), 2);
    check("t5_no_err", int'(bus.load_err), 0);
    next_cyc();
    bus.load_valid = 1'b1;
    bus.load_mode  = 2'd3;
    next_cyc();
    bus.load_valid = 1'b0;
    sample();
    check("t5_err_pulse", int'(bus.load_err), 1);
    check("t5_mode_kept", int'(bus.mode), 2);
    next_cyc(); sample();
    check("t5_err_once", int'(bus.load_err), 0);
    bus.req_in[0] = 1'b1;
    next_cyc();
    bus.load_valid = 1'b1;
    bus.load_mode  = 2'd0;
    expect_step(0, 1);
    next_cyc();
    bus.load_valid = 1'b0;
    sample();
    check("t5_load_wins", int'(bus.mode), 0);
    check("t5_pending_kept", int'(bus.pending), 1);
    check("t5_no_grant", int'(bus.step_pulse), 0);
    next_cyc(); sample();
    check("t5_grant_late", int'(bus.step_pulse), 1);
    check("t5_busy", int'(bus.busy), 1);

    // 6: reset in LOCK with req_in[0] held high
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    sample();
    check("t6_mode", int'(bus.mode), 0);
    check("t6_grant_id", int'(bus.grant_id), 0);
    check("t6_pending", int'(bus.pending), 0);
    check("t6_step", int'(bus.step_pulse), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_load_err", int'(bus.load_err), 0);
    check("t6_drop", int'(bus.drop_sticky), 0);
    for (int k = 1; k <= 4; k++) begin
      next_cyc(); sample();
      check($sformatf("t6_held_c%0d", k), int'(bus.pending), 0);
    end
    next_cyc();
    bus.req_in[0] = 1'b0;
    next_cyc();
    bus.req_in[0] = 1'b1;
    expect_step(0, 1);
    repeat (6) next_cyc();
    sample();
    check("t6_steps", n_steps, exp_steps);

    check("sb_empty", sb.size(), 0);
    check("step_total", n_steps, exp_steps);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
